// File: rtl/scrolling_graph_ctrl.sv
// Peak-preserving decimator, saturating scaler and FIFO that releases
// samples to the scrolling graph only during vertical blanking.
module scrolling_graph_ctrl #(
  parameter int SCREEN_WIDTH    = 1280,
  parameter int SCREEN_HEIGHT   = 720,
  parameter int IN_WIDTH        = 12,
  parameter int DATA_RESOLUTION = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                                  clk_in,
  input  logic                                  rst_n_in,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0]      vcount_in,
  input  logic                                  sample_valid_in,
  input  logic signed [IN_WIDTH-1:0]            sample_in,
  input  logic [7:0]                            decim_in,
  input  logic [3:0]                            shift_in,
  input  logic [3:0]                            writes_per_frame_in,
  input  logic                                  freeze_in,
  output logic                                  data_valid_out,
  output logic signed [DATA_RESOLUTION-1:0]     data_out,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level_out,
  output logic [15:0]                           overflow_count_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int VW = (SCREEN_WIDTH > 0) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [IN_WIDTH-1:0] SMAX =
    IN_WIDTH'((1 << (DATA_RESOLUTION-1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    WAIT_ACTIVE,
    WAIT_BLANK,
    DRAIN
  } state_t;

  logic                              take;
  logic                              first;
  logic                              last;
  logic [7:0]                        cnt;
  logic [7:0]                        d_lat;
  logic [7:0]                        d_eff;
  logic signed [IN_WIDTH-1:0]        peak;
  logic signed [IN_WIDTH-1:0]        win_pk;
  logic signed [IN_WIDTH-1:0]        shifted;
  logic [IN_WIDTH:0]                 sx;
  logic [IN_WIDTH:0]                 s_abs;
  logic [IN_WIDTH:0]                 peak_abs;
  logic [IN_WIDTH:0]                 win_abs;
  logic signed [DATA_RESOLUTION-1:0] sat;
  logic                              push_v;
  logic signed [DATA_RESOLUTION-1:0] push_d;

  assign take = sample_valid_in && !freeze_in;

  always_comb begin
    first   = (cnt == 8'd0);
    d_eff   = d_lat;
    if (first)
      d_eff = (decim_in == 8'd0) ? 8'd1 : decim_in;
    sx      = {sample_in[IN_WIDTH-1], sample_in};
    s_abs   = sx[IN_WIDTH] ? (~sx + 1'b1) : sx;
    win_pk  = peak;
    win_abs = peak_abs;
    // strict compare: on a tie the earlier sample wins
    if (first || s_abs > peak_abs) begin
      win_pk  = sample_in;
      win_abs = s_abs;
    end
    last    = ((cnt + 8'd1) == d_eff);
    shifted = win_pk >>> shift_in;
    if (shifted > SMAX)
      sat = DATA_RESOLUTION'(SMAX);
    else if (shifted < SMIN)
      sat = DATA_RESOLUTION'(SMIN);
    else
      sat = DATA_RESOLUTION'(shifted);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cnt      <= '0;
      d_lat    <= '0;
      peak     <= '0;
      peak_abs <= '0;
      push_v   <= 1'b0;
      push_d   <= '0;
    end else begin
      push_v <= take && last;
      if (take) begin
        if (first)
          d_lat <= d_eff;
        peak     <= win_pk;
        peak_abs <= win_abs;
        push_d   <= sat;
        cnt      <= last ? 8'd0 : cnt + 8'd1;
      end
    end
  end

  state_t                            state;
  state_t                            state_n;
  logic [3:0]                        budget;
  logic [3:0]                        budget_n;
  logic                              blank;
  logic                              pop;
  logic                              push_ok;
  logic [AW-1:0]                     wptr;
  logic [AW-1:0]                     rptr;
  logic signed [DATA_RESOLUTION-1:0] mem [FIFO_DEPTH];

  assign blank   = vcount_in >= VW'(SCREEN_HEIGHT);
  assign pop     = (state == DRAIN) && (fifo_level_out != '0) &&
                   (budget != 4'd0) && !freeze_in;
  assign push_ok = push_v && ((fifo_level_out != FULL) || pop);

  always_comb begin
    state_n  = state;
    budget_n = budget;
    unique case (state)
      WAIT_ACTIVE: if (!blank) state_n = WAIT_BLANK;
      WAIT_BLANK: begin
        if (blank) begin
          state_n  = DRAIN;
          budget_n = writes_per_frame_in;
        end
      end
      DRAIN: begin
        if (pop)
          budget_n = budget - 4'd1;
        if (budget_n == 4'd0 || !blank)
          state_n = WAIT_ACTIVE;
      end
      default: state_n = WAIT_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push_ok)
      mem[wptr] <= push_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state              <= WAIT_ACTIVE;
      budget             <= '0;
      wptr               <= '0;
      rptr               <= '0;
      fifo_level_out     <= '0;
      overflow_count_out <= '0;
      data_valid_out     <= 1'b0;
      data_out           <= '0;
    end else begin
      state          <= state_n;
      budget         <= budget_n;
      data_valid_out <= pop;
      if (pop) begin
        data_out <= mem[rptr];
        rptr     <= rptr + 1'b1;
      end
      if (push_ok)
        wptr <= wptr + 1'b1;
      if (push_ok && !pop)
        fifo_level_out <= fifo_level_out + 1'b1;
      else if (pop && !push_ok)
        fifo_level_out <= fifo_level_out - 1'b1;
      if (push_v && !push_ok && overflow_count_out != 16'hFFFF)
        overflow_count_out <= overflow_count_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_scrolling_graph_ctrl.sv
// Directed bench for scrolling_graph_ctrl with a queue scoreboard
// checking every graph write strobe.
module tb_scrolling_graph_ctrl;

  localparam int H = 720;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic [9:0]        vcount_in;
  logic              sample_valid_in;
  logic signed [11:0] sample_in;
  logic [7:0]        decim_in;
  logic [3:0]        shift_in;
  logic [3:0]        writes_per_frame_in;
  logic              freeze_in;
  logic              data_valid_out;
  logic signed [7:0] data_out;
  logic [4:0]        fifo_level_out;
  logic [15:0]       overflow_count_out;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int s0;
  int q[$];

  scrolling_graph_ctrl dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .vcount_in           (vcount_in),
    .sample_valid_in     (sample_valid_in),
    .sample_in           (sample_in),
    .decim_in            (decim_in),
    .shift_in            (shift_in),
    .writes_per_frame_in (writes_per_frame_in),
    .freeze_in           (freeze_in),
    .data_valid_out      (data_valid_out),
    .data_out            (data_out),
    .fifo_level_out      (fifo_level_out),
    .overflow_count_out  (overflow_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk_in) begin
    cyc++;
    if (rst_n_in && data_valid_out) begin
      strobes++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (q.size() == 0)
        chk("data_unexpected", int'(data_out), 9999);
      else
        chk("data", int'(data_out), q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int x);
    sample_valid_in = 1'b1;
    sample_in = 12'(x);
    step();
    sample_valid_in = 1'b0;
  endtask

  task automatic frame(input int n);
    vcount_in = 10'(H);
    repeat (n) step();
    vcount_in = 10'd0;
    repeat (3) step();
  endtask

  initial begin
    rst_n_in = 1'b0;
    vcount_in = 10'd0;
    sample_valid_in = 1'b0;
    sample_in = '0;
    decim_in = 8'd1;
    shift_in = 4'd0;
    writes_per_frame_in = 4'd4;
    freeze_in = 1'b0;
    repeat (2) step();
    rst_n_in = 1'b1;
    step();
    chk("rst_valid", int'(data_valid_out), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_level", int'(fifo_level_out), 0);
    chk("rst_ovf", int'(overflow_count_out), 0);

    // basic drain
    send(10);  q.push_back(10);
    send(-20); q.push_back(-20);
    send(30);  q.push_back(30);
    send(40);  q.push_back(40);
    send(50);  q.push_back(50);
    repeat (2) step();
    chk("basic_level5", int'(fifo_level_out), 5);
    s0 = strobes; first_cyc = -1;
    frame(10);
    chk("basic_strobes4", strobes - s0, 4);
    chk("basic_contig", last_cyc - first_cyc, 3);
    chk("basic_level1", int'(fifo_level_out), 1);
    s0 = strobes;
    frame(10);
    chk("basic_strobes1", strobes - s0, 1);
    chk("basic_level0", int'(fifo_level_out), 0);

    // peak and saturation
    decim_in = 8'd4;
    shift_in = 4'd2;
    send(100); send(-900); send(800); send(5);
    q.push_back(-128);
    repeat (4) send(-2048);
    q.push_back(-128);
    send(400); send(-400); send(0); send(0);
    q.push_back(100);
    repeat (2) step();
    chk("peak_level3", int'(fifo_level_out), 3);
    s0 = strobes;
    frame(10);
    chk("peak_strobes3", strobes - s0, 3);
    chk("peak_level0", int'(fifo_level_out), 0);

    // overflow
    decim_in = 8'd1;
    shift_in = 4'd0;
    writes_per_frame_in = 4'd0;
    for (int i = 1; i <= 20; i++) begin
      send(i);
      if (i <= 16) q.push_back(i);
    end
    repeat (2) step();
    chk("ovf_level16", int'(fifo_level_out), 16);
    chk("ovf_count4", int'(overflow_count_out), 4);
    s0 = strobes;
    frame(10);
    chk("ovf_paused", strobes - s0, 0);
    writes_per_frame_in = 4'd15;
    s0 = strobes;
    frame(20);
    chk("ovf_strobes15", strobes - s0, 15);
    chk("ovf_level1", int'(fifo_level_out), 1);
    s0 = strobes;
    frame(20);
    chk("ovf_strobes1", strobes - s0, 1);

    // freeze
    writes_per_frame_in = 4'd4;
    send(5); q.push_back(5);
    send(6); q.push_back(6);
    send(7); q.push_back(7);
    decim_in = 8'd4;
    send(60); send(-70);
    freeze_in = 1'b1;
    repeat (3) send(500);
    s0 = strobes;
    frame(6);
    frame(6);
    chk("frz_strobes", strobes - s0, 0);
    chk("frz_level3", int'(fifo_level_out), 3);
    chk("frz_ovf", int'(overflow_count_out), 4);
    freeze_in = 1'b0;
    send(10); send(20);
    q.push_back(-70);
    repeat (2) step();
    chk("frz_level4", int'(fifo_level_out), 4);
    s0 = strobes;
    frame(10);
    chk("frz_strobes4", strobes - s0, 4);

    // full FIFO with coincident push and pop
    decim_in = 8'd1;
    writes_per_frame_in = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      send(i);
      q.push_back(i);
    end
    repeat (2) step();
    chk("full_level16", int'(fifo_level_out), 16);
    writes_per_frame_in = 4'd4;
    s0 = strobes;
    vcount_in = 10'(H);
    send(99); q.push_back(99);
    step();
    chk("full_pushpop_level", int'(fifo_level_out), 16);
    chk("full_pushpop_ovf", int'(overflow_count_out), 4);
    repeat (10) step();
    vcount_in = 10'd0;
    repeat (3) step();
    chk("full_strobes4", strobes - s0, 4);
    chk("full_level13", int'(fifo_level_out), 13);

    // reset mid-blanking with data queued
    writes_per_frame_in = 4'd15;
    vcount_in = 10'(H + 2);
    rst_n_in = 1'b0;
    s0 = strobes;
    repeat (2) step();
    rst_n_in = 1'b1;
    q.delete();
    step();
    chk("mrst_valid", int'(data_valid_out), 0);
    chk("mrst_data", int'(data_out), 0);
    chk("mrst_level", int'(fifo_level_out), 0);
    chk("mrst_ovf", int'(overflow_count_out), 0);
    repeat (10) step();
    chk("mrst_strobes", strobes - s0, 0);
    vcount_in = 10'd0;
    repeat (3) step();

    // three-cycle blanking
    writes_per_frame_in = 4'd8;
    for (int i = 1; i <= 10; i++) begin
      send(i);
      q.push_back(i);
    end
    repeat (2) step();
    chk("edge_level10", int'(fifo_level_out), 10);
    s0 = strobes;
    frame(3);
    chk("edge_strobes3", strobes - s0, 3);
    chk("edge_level7", int'(fifo_level_out), 7);
    s0 = strobes;
    frame(12);
    chk("edge_strobes7", strobes - s0, 7);
    chk("edge_level0", int'(fifo_level_out), 0);
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scrolling_graph_ctrl.md
# scrolling_graph_ctrl

Sample scheduler that feeds the scrolling EKG graph's write port. It accepts raw signed ECG samples at an arbitrary rate and decimates them with a peak-preserving window. Each result is scaled and saturated to the graph's data width, then buffered in a small FIFO. The FIFO is released to the graph only during vertical blanking, at a programmable number of writes per frame, so the trace scrolls at a fixed speed with no tearing. Sits between the filter/ADC front end and the graph's `data_valid_in`/`data_in`, in the HDMI clock domain.

## Interface

Parameters:
- `SCREEN_WIDTH`, 1280: active pixels per line; sets `vcount_in` width with `SCREEN_HEIGHT`.
- `SCREEN_HEIGHT`, 720: active lines; `vcount_in >= SCREEN_HEIGHT` means vertical blanking.
- `IN_WIDTH`, 12: raw sample width (signed).
- `DATA_RESOLUTION`, 8: output sample width (signed); matches the graph.
- `FIFO_DEPTH`, 16: FIFO entries; power of two.

Ports:
- `clk_in`  in  1  HDMI pixel clock; sole clock.
- `rst_n_in`  in  1  reset, synchronous, active-low.
- `vcount_in`  in  $clog2(SCREEN_HEIGHT)  current line from the video timing generator.
- `sample_valid_in`  in  1  one-cycle strobe; `sample_in` valid.
- `sample_in`  in  IN_WIDTH  signed raw sample.
- `decim_in`  in  8  decimation factor D; 0 is treated as 1.
- `shift_in`  in  4  arithmetic right shift applied to the window peak.
- `writes_per_frame_in`  in  4  max graph writes per blanking interval; 0 means paused.
- `freeze_in`  in  1  hold the display: no pops, input ignored.
- `data_valid_out`  out  1  write strobe to the graph.
- `data_out`  out  DATA_RESOLUTION  signed sample to the graph.
- `fifo_level_out`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow_count_out`  out  16  pushes dropped because the FIFO was full; saturates at 0xFFFF.

## Operation

- **Decimator**
  - Counts accepted samples in a window of D samples.
  - D is latched at the first sample of each window; changes to `decim_in` take effect at the next window.
  - Tracks the peak: the sample with the largest |x|, computed in IN_WIDTH+1 bits so that −2^(IN_WIDTH−1) is correct. On a tie, the earlier sample is kept.
  - At the D-th sample the peak is shifted arithmetically right by `shift_in` and saturated to [−2^(DR−1), 2^(DR−1)−1], then pushed.
- **Freeze**
  - While `freeze_in`=1, samples are ignored: no accumulation, not counted as overflow.
  - The window counter and the partial window are held.
  - No pops occur.
- **FIFO**
  - A push succeeds if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the push is dropped and `overflow_count_out` increments.
  - A simultaneous push and pop leaves the level unchanged.
- **Drain FSM**
  - WAIT_ACTIVE → WAIT_BLANK when `vcount_in < SCREEN_HEIGHT`.
  - WAIT_BLANK → DRAIN when `vcount_in >= SCREEN_HEIGHT`; the budget loads from `writes_per_frame_in`.
  - In DRAIN, one pop occurs per cycle when the FIFO is non-empty, budget > 0 and `freeze_in`=0. Each pop decrements the budget.
  - DRAIN → WAIT_ACTIVE when the budget reaches 0 or `vcount_in < SCREEN_HEIGHT`.
  - An empty FIFO in DRAIN does not exit the state; samples arriving later in the same blanking may still be drained.
  - Result: at most one drain per frame and at most `writes_per_frame_in` writes.

## Timing

- Reset (`rst_n_in`=0 at a clock edge) clears everything:
  - outputs: `data_valid_out`=0, `data_out`=0, `fifo_level_out`=0, `overflow_count_out`=0;
  - internal state: FIFO empty, window counter 0, FSM in WAIT_ACTIVE.
- Reset mid-blanking therefore produces no writes until the next blanking interval.
- Push latency: the result of the D-th sample's cycle is visible in `fifo_level_out` two cycles later.
- Pop latency: `data_valid_out` is high for exactly one cycle, in the cycle after the pop decision; `data_out` is registered in the same cycle. `data_out` holds its value when `data_valid_out`=0.
- Maximum write rate is one per cycle; back-to-back pops produce contiguous strobes.
- `writes_per_frame_in` is sampled only on entry to DRAIN.

## Test plan

- **Basic drain:** D=1, shift=0, writes=4. Push samples 10, −20, 30, 40, 50 during active video. At blanking entry, exactly 4 strobes: 10, −20, 30, 40 on consecutive cycles. Level goes 5→1. Next frame: one strobe of 50.
- **Peak and saturation:** D=4, shift=2, IN=12, DR=8. Window 100, −900, 800, 5: peak −900 → −225 → saturates to −128. Window −2048 ×4 → −128. Window 400, −400, 0, 0: tie keeps 400 → 100.
- **Overflow:** writes=0, push 20 samples with D=1. Level saturates at 16 and `overflow_count_out`=4. Setting writes=15 then drains 15 in one blanking, and the remaining one in the next.
- **Freeze:** assert freeze with 3 queued and a window 2 of 4 through. Over 2 blankings: no strobes, level 3, no overflow increments while samples are applied. Deassert freeze, feed 2 samples: window completes and level becomes 4.
- **Full with simultaneous push/pop:** FIFO full during DRAIN, a push coincides with a pop. Level stays 16 and the overflow count is unchanged.
- **Reset and blanking edges:** apply reset at `vcount_in`=SCREEN_HEIGHT+2 with data queued: all outputs 0 and no strobes until the next blanking. Enter DRAIN with 10 queued, writes=8, and blanking lasting 3 cycles: exactly 3 strobes.
